// File: rtl/irq_pkg.sv
// irq_pkg: shared constants for the timer / interrupt controller.
//   - default register window base address
//   - register word offsets (Address[4:2])
//   - FSM state encoding and interrupt cause codes
//   - fixed-priority cause selection helper
package irq_pkg;

  localparam logic [31:0] IRQ_BASE_ADDR = 32'h4000_0000;

  // Word offsets within the 32-byte window
  localparam logic [2:0] OFF_TH     = 3'd0;
  localparam logic [2:0] OFF_TL     = 3'd1;
  localparam logic [2:0] OFF_TCON   = 3'd2;
  localparam logic [2:0] OFF_IMASK  = 3'd3;
  localparam logic [2:0] OFF_IPEND  = 3'd4;
  localparam logic [2:0] OFF_ICAUSE = 3'd5;

  // FSM states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  // Cause codes; each one is also the bit index of its source in IPEND
  localparam logic [1:0] CAUSE_EXT0  = 2'd0;
  localparam logic [1:0] CAUSE_EXT1  = 2'd1;
  localparam logic [1:0] CAUSE_TIMER = 2'd2;

  // Fixed priority ext0 > ext1 > timer. Only called when eff != 0.
  function automatic logic [1:0] prio_cause(input logic [2:0] eff);
    if (eff[0])      return CAUSE_EXT0;
    else if (eff[1]) return CAUSE_EXT1;
    else             return CAUSE_TIMER;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if: MEM-stage data bus as seen by the controller.
//   Address   - byte address           (master -> slave)
//   WriteData - store data             (master -> slave)
//   MemWrite  - store strobe           (master -> slave)
//   MemRead   - load strobe            (master -> slave)
//   ReadData  - combinational load data (slave -> master), 0 when not hit
//   Hit       - access falls in the register window (slave -> master)
// Handshake: there is no valid/ready back-pressure. An access is a single
// cycle with MemRead or MemWrite high; loads are answered combinationally in
// that same cycle and stores commit on the next rising clk edge. Hit acts as
// the "valid" for ReadData.
interface irq_controller_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (output Address, WriteData, MemWrite, MemRead,
                  input  ReadData, Hit);
  modport slave  (input  Address, WriteData, MemWrite, MemRead,
                  output ReadData, Hit);
endinterface

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: 2-FF synchronizer followed by a rising-edge detector.
//   clk      - system clock
//   reset    - asynchronous, active-low
//   async_in - asynchronous external level
//   rise     - one-cycle pulse when the synchronized level goes 0 -> 1
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // High for exactly one cycle per rising level; a held level never re-fires.
  assign rise = sync2_q & ~prev_q;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: memory-mapped reloadable timer plus two edge-triggered
// external interrupt lines, sequenced one at a time as REQ -> SERVICE -> IDLE.
//   clk        - system clock
//   reset      - asynchronous, active-low; clears all state
//   bus        - MEM-stage data bus (slave side)
//   ext_irq    - asynchronous external requests, rising-edge sensitive
//   Interrupt  - request to the hazard/jump unit (high exactly in REQ)
//   IntCause   - latched source: 0 ext0, 1 ext1, 2 timer
//   IntAck     - pulse: pipeline has redirected to the handler
//   IntEret    - pulse: handler return has retired
//   dbg_state  - current FSM state
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IRQ_BASE_ADDR
) (
  input  logic             clk,
  input  logic             reset,
  irq_controller_if.slave  bus,
  input  logic [1:0]       ext_irq,
  output logic             Interrupt,
  output logic [1:0]       IntCause,
  input  logic             IntAck,
  input  logic             IntEret,
  output logic [1:0]       dbg_state
);

  logic [31:0] th_q, tl_q, th_d, tl_d;
  logic [1:0]  tcon_q, tcon_d;     // [0] enable, [1] timer IRQ enable
  logic [1:0]  imask_q, imask_d;
  logic [2:0]  ipend_q, ipend_d;   // {timer, ext1, ext0}
  logic [1:0]  state_q, state_d;
  logic [1:0]  cause_q, cause_d;

  logic [2:0]  off;
  logic        we;
  logic        wr_th, wr_tl, wr_tcon, wr_imask, wr_ipend;
  logic [1:0]  ext_rise;
  logic        wrap;
  logic        ack_take;
  logic [2:0]  eff, ipend_set, ipend_clr;

  // Byte-lane bits are ignored by the decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.Address[1:0];

  irq_sync_edge u_sync0 (.clk(clk), .reset(reset), .async_in(ext_irq[0]), .rise(ext_rise[0]));
  irq_sync_edge u_sync1 (.clk(clk), .reset(reset), .async_in(ext_irq[1]), .rise(ext_rise[1]));

  // ---------------- bus decode ----------------
  assign off      = bus.Address[4:2];
  assign bus.Hit  = (bus.Address[31:5] == BASE_ADDR[31:5]) && (bus.MemRead || bus.MemWrite);
  assign we       = bus.Hit && bus.MemWrite;
  assign wr_th    = we && (off == OFF_TH);
  assign wr_tl    = we && (off == OFF_TL);
  assign wr_tcon  = we && (off == OFF_TCON);
  assign wr_imask = we && (off == OFF_IMASK);
  assign wr_ipend = we && (off == OFF_IPEND);

  always_comb begin
    bus.ReadData = 32'd0;
    if (bus.Hit) begin
      case (off)
        OFF_TH:     bus.ReadData = th_q;
        OFF_TL:     bus.ReadData = tl_q;
        OFF_TCON:   bus.ReadData = {29'd0, ipend_q[2], tcon_q};
        OFF_IMASK:  bus.ReadData = {30'd0, imask_q};
        OFF_IPEND:  bus.ReadData = {29'd0, ipend_q};
        OFF_ICAUSE: bus.ReadData = {28'd0, state_q, cause_q};
        default:    bus.ReadData = 32'd0;
      endcase
    end
  end

  // ---------------- timer and config registers ----------------
  assign wrap = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    tl_d = tl_q;
    if (tcon_q[0]) tl_d = wrap ? th_q : tl_q + 32'd1;
    // Software write wins over the hardware count/reload.
    if (wr_tl) tl_d = bus.WriteData;
    th_d    = wr_th    ? bus.WriteData      : th_q;
    tcon_d  = wr_tcon  ? bus.WriteData[1:0] : tcon_q;
    imask_d = wr_imask ? bus.WriteData[1:0] : imask_q;
  end

  // ---------------- pending bits ----------------
  // TCON[2] is an alias of IPEND[2], so a TCON write of 1 there clears it too.
  // Sets are OR-ed in after clears so a hardware event in the same cycle wins.
  assign ack_take  = (state_q == ST_REQ) && IntAck;
  assign ipend_set = {wrap, ext_rise};
  always_comb begin
    ipend_clr = 3'd0;
    if (wr_ipend) ipend_clr = ipend_clr | bus.WriteData[2:0];
    if (wr_tcon)  ipend_clr = ipend_clr | {bus.WriteData[2], 2'b00};
    if (ack_take) ipend_clr = ipend_clr | (3'b001 << cause_q);
    ipend_d = (ipend_q & ~ipend_clr) | ipend_set;
  end

  assign eff = ipend_q & {tcon_q[1], imask_q};

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: if (eff != 3'd0) begin
        state_d = ST_REQ;
        cause_d = prio_cause(eff);
      end
      ST_REQ:     if (IntAck)  state_d = ST_SERVICE;
      ST_SERVICE: if (IntEret) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q    <= 32'd0;
      tl_q    <= 32'd0;
      tcon_q  <= 2'd0;
      imask_q <= 2'd0;
      ipend_q <= 3'd0;
      state_q <= ST_IDLE;
      cause_q <= CAUSE_EXT0;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      tcon_q  <= tcon_d;
      imask_q <= imask_d;
      ipend_q <= ipend_d;
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Decoded straight from the state flop, so it is glitch-free and drops
  // with the asynchronous reset.
  assign Interrupt = (state_q == ST_REQ);
  assign IntCause  = cause_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
  import irq_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] A_TH     = BASE + 32'h00;
  localparam logic [31:0] A_TL     = BASE + 32'h04;
  localparam logic [31:0] A_TCON   = BASE + 32'h08;
  localparam logic [31:0] A_IMASK  = BASE + 32'h0C;
  localparam logic [31:0] A_IPEND  = BASE + 32'h10;
  localparam logic [31:0] A_ICAUSE = BASE + 32'h14;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] ext_irq = 2'b00;
  logic       IntAck = 1'b0;
  logic       IntEret = 1'b0;
  logic       Interrupt;
  logic [1:0] IntCause;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  irq_controller_if bus ();

  irq_controller #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus), .ext_irq(ext_irq),
    .Interrupt(Interrupt), .IntCause(IntCause),
    .IntAck(IntAck), .IntEret(IntEret), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic        rd_chk = 1'b0;
  logic        irq_chk = 1'b0;

  task automatic push_exp(input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic compare(input logic [31:0] act);
    logic [31:0] e;
    string nm;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL no_expectation: actual=%h required=<none>", act);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: actual=%h required=%h at %0t", nm, act, e, $time);
      end
    end
  endtask

  // Monitor: samples on the falling edge whenever a check strobe is active.
  always @(negedge clk) begin
    if (rd_chk)  compare(bus.ReadData);
    if (irq_chk) compare({29'd0, Interrupt, IntCause});
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.Address = a; bus.WriteData = d; bus.MemWrite = 1'b1;
    cyc();
    bus.MemWrite = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
    push_exp(e, nm);
    bus.Address = a; bus.MemRead = 1'b1; rd_chk = 1'b1;
    cyc();
    bus.MemRead = 1'b0; rd_chk = 1'b0;
  endtask

  task automatic check_irq(input logic i, input logic [1:0] c, input string nm);
    push_exp({29'd0, i, c}, nm);
    irq_chk = 1'b1;
    cyc();
    irq_chk = 1'b0;
  endtask

  task automatic pulse_ack();
    IntAck = 1'b1; cyc(); IntAck = 1'b0;
  endtask

  task automatic pulse_eret();
    IntEret = 1'b1; cyc(); IntEret = 1'b0;
  endtask

  // Bounds the whole run in case anything stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.Address = 32'd0; bus.WriteData = 32'd0;
    bus.MemWrite = 1'b0; bus.MemRead = 1'b0;

    // Reset held with ext lines high and random traffic: reads 0, no IRQ.
    ext_irq = 2'b11;
    cyc();
    for (int i = 0; i < 6; i++) begin
      bus.Address   = BASE + 32'($urandom_range(0, 7)) * 32'd4;
      bus.WriteData = $urandom;
      bus.MemWrite  = 1'($urandom_range(0, 1));
      push_exp(32'd0, "reset_read");
      bus.MemRead = 1'b1; rd_chk = 1'b1;
      cyc();
      bus.MemRead = 1'b0; bus.MemWrite = 1'b0; rd_chk = 1'b0;
    end
    check_irq(1'b0, 2'd0, "reset_irq");
    reset = 1'b1;
    bus_read(A_ICAUSE, 32'd0, "icause_after_reset");
    ext_irq = 2'b00;
    repeat (5) cyc();
    bus_write(A_IPEND, 32'h7);
    bus_read(A_IPEND, 32'd0, "ipend_cleared");
    bus_read(BASE + 32'h20, 32'd0, "miss_read");
    bus_read(BASE + 32'h18, 32'd0, "reserved_read");

    // Timer wrap and reload.
    bus_write(A_TH, 32'hFFFF_FFFC);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h3);
    bus_read(A_TL, 32'hFFFF_FFFE, "tl_before_inc");
    bus_read(A_TL, 32'hFFFF_FFFF, "tl_max");
    bus_read(A_TL, 32'hFFFF_FFFC, "tl_reload");
    check_irq(1'b1, CAUSE_TIMER, "timer_irq");
    bus_read(A_TCON, 32'h7, "tcon_pending");
    bus_write(A_TCON, 32'h2);              // stop counting, keep IRQ enable
    bus_read(A_TH, 32'hFFFF_FFFC, "th_value");
    pulse_ack();
    bus_read(A_TCON, 32'h2, "tcon_after_ack");
    check_irq(1'b0, CAUSE_TIMER, "timer_service");
    pulse_eret();
    check_irq(1'b0, CAUSE_TIMER, "idle_after_eret");

    // Priority: timer, ext1, ext0 all pending, then unmasked.
    bus_write(A_TCON, 32'h0);
    bus_write(A_TH, 32'h0);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h1);
    bus_write(A_TCON, 32'h0);
    ext_irq = 2'b11;
    repeat (4) cyc();
    ext_irq = 2'b00;
    repeat (4) cyc();
    bus_read(A_IPEND, 32'h7, "all_pending");
    bus_write(A_IMASK, 32'h3);
    bus_write(A_TCON, 32'h2);
    check_irq(1'b1, CAUSE_EXT0, "prio_first");
    pulse_ack();
    pulse_eret();
    cyc();
    check_irq(1'b1, CAUSE_EXT1, "prio_second");
    pulse_ack();
    pulse_eret();
    cyc();
    check_irq(1'b1, CAUSE_TIMER, "prio_third");
    pulse_ack();
    pulse_eret();
    bus_read(A_IPEND, 32'h0, "prio_all_cleared");

    // Non-nesting and back-to-back re-request.
    ext_irq = 2'b10;
    repeat (5) cyc();
    ext_irq = 2'b00;
    check_irq(1'b1, CAUSE_EXT1, "ext1_req");
    bus_read(A_ICAUSE, 32'h5, "icause_req");
    pulse_eret();                          // ignored outside SERVICE
    check_irq(1'b1, CAUSE_EXT1, "eret_ignored");
    pulse_ack();
    check_irq(1'b0, CAUSE_EXT1, "ack_drops_irq");
    bus_read(A_ICAUSE, 32'h9, "icause_service");
    ext_irq = 2'b01;
    repeat (5) cyc();
    ext_irq = 2'b00;
    bus_read(A_IPEND, 32'h1, "pend_in_service");
    check_irq(1'b0, CAUSE_EXT1, "no_nesting");
    pulse_eret();
    check_irq(1'b0, CAUSE_EXT1, "idle_one_edge");
    check_irq(1'b1, CAUSE_EXT0, "rerequest_two_edges");
    pulse_ack();
    pulse_eret();

    // Races: W1C vs. edge set, TL write vs. wrap.
    bus_write(A_IMASK, 32'h0);
    ext_irq = 2'b01;
    cyc();
    cyc();
    bus_write(A_IPEND, 32'h1);            // lands on the edge-detect cycle
    bus_read(A_IPEND, 32'h1, "set_beats_w1c");
    ext_irq = 2'b00;
    bus_write(A_IPEND, 32'h1);
    bus_read(A_IPEND, 32'h0, "w1c_plain");
    bus_write(A_TCON, 32'h1);
    bus_write(A_TL, 32'hFFFF_FFFE);
    cyc();
    bus_write(A_TL, 32'h5);               // lands on the wrap edge
    bus_read(A_TL, 32'h5, "tl_write_wins");
    bus_write(A_TCON, 32'h0);
    bus_read(A_IPEND, 32'h4, "wrap_still_sets");
    bus_write(A_IPEND, 32'h4);
    bus_read(A_IPEND, 32'h0, "timer_pend_cleared");
    check_irq(1'b0, CAUSE_EXT0, "masked_no_irq");

    // Mid-operation reset.
    bus_write(A_IMASK, 32'h1);
    ext_irq = 2'b01;
    repeat (5) cyc();
    check_irq(1'b1, CAUSE_EXT0, "pre_reset_req");
    ext_irq = 2'b11;
    repeat (4) cyc();
    bus_read(A_IPEND, 32'h3, "pre_reset_pend");
    reset = 1'b0;                          // between edges
    check_irq(1'b0, 2'd0, "async_drop");
    ext_irq = 2'b00;
    cyc();
    reset = 1'b1;
    bus_read(A_IPEND, 32'h0, "pend_lost");
    bus_read(A_ICAUSE, 32'h0, "icause_idle");
    bus_read(A_IMASK, 32'h0, "imask_reset");
    check_irq(1'b0, 2'd0, "post_reset_irq");

    repeat (2) cyc();
    while (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unchecked_%s: actual=<not sampled> required=%h",
               name_q.pop_front(), exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped timer and interrupt controller for the pipelined CPU. It sits beside the MEM stage on the data bus and drives the interrupt request into the hazard/jump unit, which today has its interrupt input tied low. It owns a reloadable 32-bit timer and two edge-triggered external lines. It sequences one interrupt at a time through request, acknowledge and return-from-handler.

## Interface
- BASE_ADDR, 32'h4000_0000: register window base, 32-byte aligned.
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- Address  in  32  MEM-stage byte address.
- WriteData  in  32  MEM-stage store data.
- MemWrite  in  1  store strobe.
- MemRead  in  1  load strobe.
- ReadData  out  32  combinational load data; 0 when not hit.
- Hit  out  1  Address in window and (MemRead|MemWrite).
- ext_irq  in  2  asynchronous external requests, rising-edge sensitive.
- Interrupt  out  1  request to hazard/jump unit, registered.
- IntCause  out  2  latched source: 0 = ext0, 1 = ext1, 2 = timer.
- IntAck  in  1  one-cycle pulse; pipeline has redirected the PC to the handler.
- IntEret  in  1  one-cycle pulse; handler return has retired.

## Operation
- Decode: the window is hit when Address[31:5]==BASE_ADDR[31:5]. Word offset is Address[4:2]. Byte bits are ignored.
- Registers:
  - +0x00 TH: reload value.
  - +0x04 TL: counter.
  - +0x08 TCON: [0] enable, [1] timer IRQ enable, [2] timer pending (read; write 1 clears).
  - +0x0C IMASK[1:0]: external line enables.
  - +0x10 IPEND[2:0]: {timer, ext1, ext0}; write 1 clears the bit.
  - +0x14 ICAUSE, read-only: {28'b0, state[1:0], IntCause}.
  - Other offsets: reads return 0; writes are ignored.
- Reset values: TH=TL=TCON=IMASK=IPEND=0, state IDLE, Interrupt=0, IntCause=0.
- Timer: when TCON[0]=1, TL increments every cycle. At TL==32'hFFFF_FFFF the next TL is TH and IPEND[2] is set. TCON[2] is an alias of IPEND[2].
- External lines: each goes through a 2-FF synchronizer and a rising-edge detector. A detected edge sets IPEND[i]. Levels held high do not re-trigger.
- Effective request: eff = IPEND & {TCON[1], IMASK}. Fixed priority: ext0 > ext1 > timer.
- FSM:
  - IDLE: if eff≠0, go to REQ and latch IntCause = highest eff source.
  - REQ: Interrupt=1. On IntAck, clear IPEND[IntCause] and go to SERVICE. The request cannot be withdrawn; later clears or masks do not drop Interrupt.
  - SERVICE: Interrupt=0; no nesting. New events still set IPEND. On IntEret, go to IDLE.
  - IntAck outside REQ and IntEret outside SERVICE are ignored.
- Simultaneous events:
  - Software write vs. hardware update of the same register in one cycle: the software write wins for TL/TH/TCON[1:0]/IMASK.
  - Hardware set vs. W1C clear of the same IPEND bit: the set wins.
  - IntAck clear vs. new edge on the same source: the new edge wins (bit stays 1).
- Reset asserted mid-operation returns everything to reset values immediately. Interrupt drops asynchronously.

## Timing
- ReadData and Hit are combinational from current state. Writes take effect at the next edge.
- External latency: ext_irq sampled high first at edge k → IPEND set at edge k+2 → Interrupt=1 after edge k+3 (if masked in and IDLE).
- Timer latency: wrap at edge n sets IPEND[2] → Interrupt=1 after edge n+1.
- Interrupt falls the edge after IntAck. The earliest re-request is the edge after IntEret sets IDLE, so Interrupt can be high again one edge later.
- Back-to-back: a pending source waiting during SERVICE raises Interrupt 2 edges after the IntEret pulse edge.

## Structure
- Package irq_pkg holds:
  - register offsets
  - FSM state encoding (IDLE=0, REQ=1, SERVICE=2)
  - cause codes
- Sub-module irq_sync_edge: 2-FF synchronizer plus edge detector with async active-low reset. Instantiated once per ext_irq bit.
- Target size about 200 lines of RTL.

## Test plan
- Reset: hold reset=0 with ext_irq=2'b11 and random bus traffic → all reads 0, Interrupt=0. Release reset → ICAUSE reads 0.
- Timer wrap: TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, TCON=3 → TL wraps to 0xFFFF_FFFC and TCON reads 7. Interrupt=1 with IntCause=2 one edge after the wrap. IntAck → TCON reads 3.
- Priority: IMASK=3, TCON[1]=1, timer pending, pulse ext1 and ext0 in the same cycle → IntCause=0 first. After Ack+Eret → IntCause=1, then IntCause=2.
- Non-nesting: while in SERVICE, an ext0 edge → IPEND reads 0x1 and Interrupt stays 0. IntEret → Interrupt=1 two edges later.
- Race: write IPEND=0x1 in the same cycle an ext0 edge is detected → IPEND[0] remains 1. Write TL=5 on the wrap cycle → TL=5, IPEND[2] set.
- Mid-operation reset: assert reset while in REQ → Interrupt drops without waiting for clk. After release, state is IDLE and pending edges are lost.
